// File: rtl/cache_pkg.sv
// Shared FSM state encoding and associativity checks for the cache level.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    FILL_REQ  = 3'd3,
    FILL_WAIT = 3'd4,
    RESPOND   = 3'd5
  } state_t;

  function automatic bit assoc_legal(input int assoc);
    return (assoc == 1) || (assoc == 2);
  endfunction

  // An illegal ASSOC value falls back to a direct-mapped cache.
  function automatic int legal_ways(input int assoc);
    return assoc_legal(assoc) ? assoc : 1;
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// Storage for one cache way: valid/dirty bits (reset) plus tag and data arrays.
module cache_way_array
  import cache_pkg::*;
#(
  parameter int INDEX_W = 2,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INDEX_W-1:0] index,
  output logic               valid,
  output logic               dirty,
  output logic [TAG_W-1:0]   tag,
  output logic [DATA_W-1:0]  data,
  input  logic               wr_en,
  input  logic               wr_dirty,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data
);

  localparam int DEPTH = 1 << INDEX_W;

  logic [DEPTH-1:0]  valid_bits;
  logic [DEPTH-1:0]  dirty_bits;
  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  // Line state bits; every write installs a valid line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (wr_en) begin
      valid_bits[index] <= 1'b1;
      dirty_bits[index] <= wr_dirty;
    end
  end

  // Tag and data payload, meaningful only while the line is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[index]  <= wr_tag;
      data_mem[index] <= wr_data;
    end
  end

  assign valid = valid_bits[index];
  assign dirty = dirty_bits[index];
  assign tag   = tag_mem[index];
  assign data  = data_mem[index];

endmodule

// File: rtl/cache_level.sv
// One-word-per-line write-back, write-allocate cache level with 1 or 2 ways,
// LRU replacement and saturating hit/miss statistics.
module cache_level
  import cache_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int INDEX_W = 2,
  parameter int ASSOC   = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              up_req_valid,
  output logic              up_req_ready,
  input  logic              up_write,
  input  logic [ADDR_W-1:0] up_addr,
  input  logic [DATA_W-1:0] up_wdata,
  output logic              up_resp_valid,
  output logic [DATA_W-1:0] up_rdata,
  output logic              up_hit,
  output logic              dn_req_valid,
  input  logic              dn_req_ready,
  output logic              dn_write,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [DATA_W-1:0] dn_wdata,
  input  logic              dn_resp_valid,
  input  logic [DATA_W-1:0] dn_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int DEPTH = 1 << INDEX_W;
  localparam int NWAYS = legal_ways(ASSOC);

  state_t state, next_state;

  logic [ADDR_W-1:0]  req_addr;
  logic [DATA_W-1:0]  req_wdata;
  logic               req_write;
  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic               vic_way;
  logic [DEPTH-1:0]   lru;

  logic [NWAYS-1:0]   way_valid, way_dirty, way_match, way_wr;
  logic [TAG_W-1:0]   way_tag  [NWAYS];
  logic [DATA_W-1:0]  way_data [NWAYS];

  logic               hit, hit_way, has_invalid, inv_way, vic_sel, vic_dirty, acc_way;
  logic [DATA_W-1:0]  hit_data, vic_data, wr_data;
  logic [TAG_W-1:0]   vic_tag;
  logic               dn_fire, install, inst_way, wr_dirty;

  assign req_index = req_addr[INDEX_W-1:0];
  assign req_tag   = req_addr[ADDR_W-1:INDEX_W];
  assign dn_fire   = dn_req_valid && dn_req_ready;

  for (genvar w = 0; w < NWAYS; w++) begin : g_way
    cache_way_array #(
      .INDEX_W(INDEX_W),
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W)
    ) u_way (
      .clk     (clk),
      .reset_n (reset_n),
      .index   (req_index),
      .valid   (way_valid[w]),
      .dirty   (way_dirty[w]),
      .tag     (way_tag[w]),
      .data    (way_data[w]),
      .wr_en   (way_wr[w]),
      .wr_dirty(wr_dirty),
      .wr_tag  (req_tag),
      .wr_data (wr_data)
    );
  end

  // Tag compare and victim choice; loops run downward so way0 wins ties.
  always_comb begin
    hit_way  = 1'b0;
    inv_way  = 1'b0;
    hit_data = '0;
    vic_data = '0;
    vic_tag  = '0;
    vic_dirty = 1'b0;
    for (int w = NWAYS - 1; w >= 0; w--) begin
      way_match[w] = way_valid[w] && (way_tag[w] == req_tag);
      hit_way      = way_match[w] ? 1'(w) : hit_way;
      inv_way      = !way_valid[w] ? 1'(w) : inv_way;
    end
    hit         = |way_match;
    has_invalid = ~&way_valid;
    vic_sel     = has_invalid ? inv_way : ((NWAYS == 2) ? lru[req_index] : 1'b0);
    for (int w = 0; w < NWAYS; w++) begin
      hit_data  = (hit_way == 1'(w)) ? way_data[w] : hit_data;
      vic_data  = (vic_sel == 1'(w)) ? way_data[w] : vic_data;
      vic_tag   = (vic_sel == 1'(w)) ? way_tag[w] : vic_tag;
      vic_dirty = (vic_sel == 1'(w)) ? (way_valid[w] && way_dirty[w]) : vic_dirty;
    end
    acc_way = hit ? hit_way : vic_sel;
  end

  // Next state plus the line install that accompanies each transition.
  always_comb begin
    next_state = state;
    install    = 1'b0;
    inst_way   = vic_way;
    wr_dirty   = 1'b1;
    wr_data    = req_wdata;
    case (state)
      IDLE: begin
        if (up_req_valid && up_req_ready) next_state = LOOKUP;
        else                              next_state = IDLE;
      end
      LOOKUP: begin
        if (hit) begin
          next_state = RESPOND;
          install    = req_write;
          inst_way   = hit_way;
        end else if (vic_dirty) begin
          next_state = WRITEBACK;
        end else if (req_write) begin
          next_state = RESPOND;
          install    = 1'b1;
          inst_way   = vic_sel;
        end else begin
          next_state = FILL_REQ;
        end
      end
      WRITEBACK: begin
        if (dn_fire) begin
          if (req_write) begin
            next_state = RESPOND;
            install    = 1'b1;
          end else begin
            next_state = FILL_REQ;
          end
        end else begin
          next_state = WRITEBACK;
        end
      end
      FILL_REQ: begin
        if (dn_fire) next_state = FILL_WAIT;
        else         next_state = FILL_REQ;
      end
      FILL_WAIT: begin
        if (dn_resp_valid) begin
          next_state = RESPOND;
          install    = 1'b1;
          wr_dirty   = 1'b0;
          wr_data    = dn_rdata;
        end else begin
          next_state = FILL_WAIT;
        end
      end
      RESPOND: next_state = IDLE;
      default: next_state = IDLE;
    endcase
    for (int w = 0; w < NWAYS; w++) begin
      way_wr[w] = install && (inst_way == 1'(w));
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Request capture, replacement bookkeeping and statistics.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_addr   <= '0;
      req_wdata  <= '0;
      req_write  <= 1'b0;
      vic_way    <= 1'b0;
      lru        <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == IDLE && up_req_valid && up_req_ready) begin
        req_addr  <= up_addr;
        req_wdata <= up_wdata;
        req_write <= up_write;
      end
      if (state == LOOKUP) begin
        vic_way        <= vic_sel;
        lru[req_index] <= ~acc_way;
        if (hit && (hit_count != {CNT_W{1'b1}}))    hit_count  <= hit_count + 1'b1;
        if (!hit && (miss_count != {CNT_W{1'b1}})) miss_count <= miss_count + 1'b1;
      end
    end
  end

  // Registered interface outputs; dn_* fields load once per request and then hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      up_req_ready  <= 1'b0;
      up_resp_valid <= 1'b0;
      up_hit        <= 1'b0;
      up_rdata      <= '0;
      dn_req_valid  <= 1'b0;
      dn_write      <= 1'b0;
      dn_addr       <= '0;
      dn_wdata      <= '0;
    end else begin
      up_req_ready  <= (next_state == IDLE);
      up_resp_valid <= (next_state == RESPOND);
      dn_req_valid  <= (next_state == WRITEBACK) || (next_state == FILL_REQ);
      if (state == LOOKUP) begin
        up_hit   <= hit;
        up_rdata <= req_write ? req_wdata : hit_data;
      end
      if (state == FILL_WAIT && dn_resp_valid) up_rdata <= dn_rdata;
      if (state == LOOKUP && next_state == WRITEBACK) begin
        dn_write <= 1'b1;
        dn_addr  <= {vic_tag, req_index};
        dn_wdata <= vic_data;
      end else if (next_state == FILL_REQ && state != FILL_REQ) begin
        dn_write <= 1'b0;
        dn_addr  <= req_addr;
        dn_wdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cache_level.sv
// Randomised bench for cache_level: a direct-mapped and a 2-way instance
// checked against a timestamp-LRU line model and a downstream memory.
module tb_cache_level;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       up_req_valid [2], up_req_ready [2], up_write [2];
  logic [7:0] up_addr [2], up_wdata [2];
  logic       up_resp_valid [2], up_hit [2];
  logic [7:0] up_rdata [2];
  logic       dn_req_valid [2], dn_req_ready [2], dn_write [2];
  logic [7:0] dn_addr [2], dn_wdata [2];
  logic       dn_resp_valid [2];
  logic [7:0] dn_rdata [2];
  logic [15:0] hit_count [2], miss_count [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cache_level #(.ADDR_W(8), .DATA_W(8), .INDEX_W(2), .ASSOC(g + 1), .CNT_W(16)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .up_req_valid(up_req_valid[g]), .up_req_ready(up_req_ready[g]), .up_write(up_write[g]),
      .up_addr(up_addr[g]), .up_wdata(up_wdata[g]),
      .up_resp_valid(up_resp_valid[g]), .up_rdata(up_rdata[g]), .up_hit(up_hit[g]),
      .dn_req_valid(dn_req_valid[g]), .dn_req_ready(dn_req_ready[g]), .dn_write(dn_write[g]),
      .dn_addr(dn_addr[g]), .dn_wdata(dn_wdata[g]),
      .dn_resp_valid(dn_resp_valid[g]), .dn_rdata(dn_rdata[g]),
      .hit_count(hit_count[g]), .miss_count(miss_count[g])
    );
  end

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
  } op_t;

  bit         m_valid [2][4][2];
  bit         m_dirty [2][4][2];
  logic [5:0] m_tag   [2][4][2];
  logic [7:0] m_data  [2][4][2];
  int         m_stamp [2][4][2];
  int         stamp_ctr = 0;
  int         m_hits [2], m_misses [2];
  logic [7:0] ref_mem [2][256];
  logic [7:0] dn_mem  [2][256];
  op_t        exp_ops [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_hits[d]   = 0;
      m_misses[d] = 0;
      for (int s = 0; s < 4; s++)
        for (int w = 0; w < 2; w++) begin
          m_valid[d][s][w] = 1'b0;
          m_dirty[d][s][w] = 1'b0;
        end
    end
  endtask

  // Line-level model: victim is an empty slot, else the least recently used one.
  task automatic model_access(input int d, input bit wr, input logic [7:0] addr,
                              input logic [7:0] wdata, output bit exp_hit,
                              output logic [7:0] exp_rdata);
    logic [1:0] s;
    logic [5:0] t;
    int hw, v;
    op_t op;
    s = addr[1:0];
    t = addr[7:2];
    hw = -1;
    v = -1;
    exp_ops.delete();
    stamp_ctr++;
    for (int w = 0; w <= d; w++)
      if (m_valid[d][s][w] && m_tag[d][s][w] == t) hw = w;
    if (hw >= 0) begin
      exp_hit = 1'b1;
      if (m_hits[d] < 65535) m_hits[d]++;
      if (wr) begin
        m_data[d][s][hw]  = wdata;
        m_dirty[d][s][hw] = 1'b1;
      end
      m_stamp[d][s][hw] = stamp_ctr;
      exp_rdata = m_data[d][s][hw];
    end else begin
      exp_hit = 1'b0;
      if (m_misses[d] < 65535) m_misses[d]++;
      for (int w = d; w >= 0; w--) if (!m_valid[d][s][w]) v = w;
      if (v < 0) begin
        v = 0;
        for (int w = 1; w <= d; w++) if (m_stamp[d][s][w] < m_stamp[d][s][v]) v = w;
      end
      if (m_valid[d][s][v] && m_dirty[d][s][v]) begin
        op.wr = 1'b1; op.addr = {m_tag[d][s][v], s}; op.data = m_data[d][s][v];
        exp_ops.push_back(op);
        ref_mem[d][op.addr] = op.data;
      end
      if (wr) begin
        m_data[d][s][v]  = wdata;
        m_dirty[d][s][v] = 1'b1;
      end else begin
        op.wr = 1'b0; op.addr = addr; op.data = ref_mem[d][addr];
        exp_ops.push_back(op);
        m_data[d][s][v]  = ref_mem[d][addr];
        m_dirty[d][s][v] = 1'b0;
      end
      m_valid[d][s][v] = 1'b1;
      m_tag[d][s][v]   = t;
      m_stamp[d][s][v] = stamp_ctr;
      exp_rdata = m_data[d][s][v];
    end
  endtask

  // One upstream transaction with a downstream responder (stall cycles, fill delay).
  task automatic transact(input int d, input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                          input int stall, input int rdelay, output bit got_hit, output logic [7:0] got_rdata);
    bit exp_hit, done, hs_armed, in_op, fill_pend, snap_wr;
    logic [7:0] exp_rdata, snap_addr, snap_wdata, fill_addr;
    int cyc, n_wait, stall_left, resp_cnt;
    op_t op;
    done = 0; hs_armed = 0; in_op = 0; fill_pend = 0; snap_wr = 0;
    snap_addr = '0; snap_wdata = '0; fill_addr = '0; stall_left = 0; resp_cnt = 0;
    got_hit = 0; got_rdata = '0;
    model_access(d, wr, addr, wdata, exp_hit, exp_rdata);
    @(negedge clk);
    up_req_valid[d] = 1'b1; up_write[d] = wr; up_addr[d] = addr; up_wdata[d] = wdata;
    n_wait = 0;
    while (!up_req_ready[d] && n_wait < 50) begin @(negedge clk); n_wait++; end
    if (n_wait >= 50) begin
      check_eq("accept_timeout", up_req_ready[d], 1'b1);
      up_req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    up_req_valid[d] = 1'b0;
    cyc = 1;
    while (!done && cyc < 300) begin
      if (hs_armed) begin
        hs_armed = 0; in_op = 0; dn_req_ready[d] = 1'b0;
        if (snap_wr) dn_mem[d][snap_addr] = snap_wdata;
        else begin fill_pend = 1; fill_addr = snap_addr; resp_cnt = rdelay; end
      end
      dn_resp_valid[d] = 1'b0;
      if (fill_pend) begin
        if (resp_cnt == 0) begin
          dn_resp_valid[d] = 1'b1; dn_rdata[d] = dn_mem[d][fill_addr]; fill_pend = 0;
        end else resp_cnt--;
      end
      if (up_resp_valid[d]) begin
        got_hit = up_hit[d]; got_rdata = up_rdata[d];
        check_eq("rdata", up_rdata[d], exp_rdata);
        check_eq("hit", up_hit[d], exp_hit);
        check_eq("dn_ops_left", exp_ops.size(), 0);
        if (exp_hit) check_eq("hit_latency", cyc, 2);
        done = 1;
      end else if (dn_req_valid[d]) begin
        if (!in_op) begin
          if (exp_ops.size() == 0) check_eq("dn_unexpected", dn_req_valid[d], 1'b0);
          else begin
            op = exp_ops.pop_front();
            check_eq("dn_write", dn_write[d], op.wr);
            check_eq("dn_addr", dn_addr[d], op.addr);
            if (op.wr) check_eq("dn_wdata", dn_wdata[d], op.data);
          end
          snap_wr = dn_write[d]; snap_addr = dn_addr[d]; snap_wdata = dn_wdata[d];
          in_op = 1; stall_left = stall;
        end else begin
          check_eq("dn_stable", {dn_write[d], dn_addr[d], dn_wdata[d]}, {snap_wr, snap_addr, snap_wdata});
        end
        if (stall_left == 0) begin dn_req_ready[d] = 1'b1; hs_armed = 1; end
        else stall_left--;
      end
      if (!done) begin @(negedge clk); cyc++; end
    end
    check_eq("resp_seen", done, 1'b1);
    dn_req_ready[d] = 1'b0;
    @(negedge clk);
    dn_resp_valid[d] = 1'b0;
    check_eq("resp_pulse", up_resp_valid[d], 1'b0);
    check_eq("hit_count", hit_count[d], m_hits[d]);
    check_eq("miss_count", miss_count[d], m_misses[d]);
  endtask

  task automatic check_reset_outputs(input int d);
    check_eq("rst_req_ready", up_req_ready[d], 1'b0);
    check_eq("rst_resp_valid", up_resp_valid[d], 1'b0);
    check_eq("rst_hit", up_hit[d], 1'b0);
    check_eq("rst_rdata", up_rdata[d], 8'h00);
    check_eq("rst_dn_valid", dn_req_valid[d], 1'b0);
    check_eq("rst_dn_write", dn_write[d], 1'b0);
    check_eq("rst_dn_addr", dn_addr[d], 8'h00);
    check_eq("rst_dn_wdata", dn_wdata[d], 8'h00);
    check_eq("rst_counts", {hit_count[d], miss_count[d]}, 32'h0);
  endtask

  // Reset while the direct-mapped instance waits for fill data.
  task automatic reset_midfill();
    int n;
    @(negedge clk);
    up_req_valid[0] = 1'b1; up_write[0] = 1'b0; up_addr[0] = 8'h14; up_wdata[0] = 8'h00;
    n = 0;
    while (!up_req_ready[0] && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    up_req_valid[0] = 1'b0;
    n = 0;
    while (!dn_req_valid[0] && n < 20) begin @(negedge clk); n++; end
    check_eq("mf_dn_valid", dn_req_valid[0], 1'b1);
    check_eq("mf_dn_addr", dn_addr[0], 8'h14);
    dn_req_ready[0] = 1'b1;
    @(negedge clk);
    dn_req_ready[0] = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_reset_outputs(0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    check_eq("ready_after_rst", up_req_ready[0], 1'b1);
    dn_resp_valid[0] = 1'b1; dn_rdata[0] = 8'h5A;
    @(negedge clk);
    dn_resp_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("stale_resp_ignored", up_resp_valid[0], 1'b0);
      @(negedge clk);
    end
  endtask

  initial begin
    bit h;
    logic [7:0] rd;
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      up_req_valid[d] = 1'b0; up_write[d] = 1'b0; up_addr[d] = '0; up_wdata[d] = '0;
      dn_req_ready[d] = 1'b0; dn_resp_valid[d] = 1'b0; dn_rdata[d] = '0;
      for (int a = 0; a < 256; a++) begin
        ref_mem[d][a] = 8'($urandom);
        dn_mem[d][a]  = ref_mem[d][a];
      end
    end
    model_reset();
    #1 check_reset_outputs(0);
    check_reset_outputs(1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("ready_first_cycle", up_req_ready[1], 1'b1);

    reset_midfill();

    ref_mem[0][8'h14] = 8'hA5;
    dn_mem[0][8'h14]  = 8'hA5;
    transact(0, 1'b0, 8'h14, 8'h00, 0, 1, h, rd);
    check_eq("cold_hit", h, 1'b0);
    check_eq("cold_rdata", rd, 8'hA5);
    check_eq("cold_miss_count", miss_count[0], 16'd1);
    transact(0, 1'b0, 8'h14, 8'h00, 0, 0, h, rd);
    check_eq("warm_hit", h, 1'b1);
    check_eq("warm_hit_count", hit_count[0], 16'd1);
    transact(0, 1'b1, 8'h14, 8'h3C, 0, 0, h, rd);
    check_eq("wr_hit", h, 1'b1);
    transact(0, 1'b0, 8'h24, 8'h00, 1, 1, h, rd);
    check_eq("evict_hit", h, 1'b0);
    check_eq("evict_wb_data", dn_mem[0][8'h14], 8'h3C);
    transact(0, 1'b0, 8'h35, 8'h00, 5, 2, h, rd);
    check_eq("stall_hit", h, 1'b0);

    transact(1, 1'b0, 8'h10, 8'h00, 0, 0, h, rd); check_eq("a2_10_first", h, 1'b0);
    transact(1, 1'b0, 8'h20, 8'h00, 0, 0, h, rd); check_eq("a2_20_first", h, 1'b0);
    transact(1, 1'b0, 8'h10, 8'h00, 0, 0, h, rd); check_eq("a2_10_again", h, 1'b1);
    transact(1, 1'b0, 8'h30, 8'h00, 0, 0, h, rd); check_eq("a2_30", h, 1'b0);
    transact(1, 1'b0, 8'h10, 8'h00, 0, 0, h, rd); check_eq("a2_10_kept", h, 1'b1);
    transact(1, 1'b0, 8'h20, 8'h00, 0, 0, h, rd); check_eq("a2_20_evicted", h, 1'b0);

    for (int i = 0; i < 160; i++) begin
      transact(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)),
               8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), h, rd);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
